// File: rtl/pipelined_add_sub_pkg.sv
// rtl/pipelined_add_sub_pkg.sv - shared constants and helpers for the pipelined adder/subtractor
package pipelined_add_sub_pkg;

   localparam logic OP_ADD    = 1'b0;
   localparam logic OP_SUB    = 1'b1;
   localparam int   MAX_WIDTH = 128;

   function automatic int slice_width(input int width, input int stages);
      return width / stages;
   endfunction

   function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
      return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
   endfunction

   // Largest positive / most negative two's-complement value of the given width.
   function automatic logic [MAX_WIDTH-1:0] sat_pos(input int width);
      logic [MAX_WIDTH-1:0] r;
      r = '0;
      for (int i = 0; i < width - 1; i++) r[i] = 1'b1;
      return r;
   endfunction

   function automatic logic [MAX_WIDTH-1:0] sat_neg(input int width);
      logic [MAX_WIDTH-1:0] r;
      r = '0;
      r[width-1] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/pipelined_add_sub_slice.sv
// rtl/pipelined_add_sub_slice.sv - one SW-bit ripple slice plus its stall-holdable stage register
module add_sub_slice
   import pipelined_add_sub_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SW    = 8,
   parameter int IDX   = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH-1:0] in_sum,
   input  logic             in_carry,
   input  logic             in_sat,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_carry,
   output logic             out_sat
);

   logic [SW-1:0]    slice_sum;
   logic             slice_carry;

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             sat_q, sat_d;

   always_comb begin
      slice_carry = in_carry;
      slice_sum   = '0;
      for (int i = 0; i < SW; i++) begin
         {slice_carry, slice_sum[i]} = full_add(in_a[IDX*SW+i], in_b[IDX*SW+i], slice_carry);
      end
   end

   // Bits of in_sum at and above this slice are still zero, so OR-ing merges the new slice.
   always_comb begin
      valid_d = valid_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      sat_d   = sat_q;
      if (!stall) begin
         valid_d = in_valid;
         a_d     = in_a;
         b_d     = in_b;
         sum_d   = in_sum | (WIDTH'(slice_sum) << (IDX * SW));
         carry_d = slice_carry;
         sat_d   = in_sat;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         sat_q   <= sat_d;
      end
   end

   assign out_valid = valid_q;
   assign out_a     = a_q;
   assign out_b     = b_q;
   assign out_sum   = sum_q;
   assign out_carry = carry_q;
   assign out_sat   = sat_q;

endmodule

// File: rtl/pipelined_add_sub.sv
// rtl/pipelined_add_sub.sv - STAGES-deep ripple adder/subtractor with flags; PIPE_ADD_SUB_SAT_EN adds saturation
module pipelined_add_sub
   import pipelined_add_sub_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
`ifdef PIPE_ADD_SUB_SAT_EN
   input  logic             sat,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero
);

   localparam int SW = slice_width(WIDTH, STAGES);
`ifdef PIPE_ADD_SUB_SAT_EN
   localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(sat_pos(WIDTH));
   localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(sat_neg(WIDTH));
`endif

   // Index 0 is the accepted operation; index k is the output register of stage k-1.
   logic             valid_s [STAGES+1];
   logic [WIDTH-1:0] a_s     [STAGES+1];
   logic [WIDTH-1:0] b_s     [STAGES+1];
   logic [WIDTH-1:0] sum_s   [STAGES+1];
   logic             carry_s [STAGES+1];
   logic             sat_s   [STAGES+1];

   logic             stall;
   logic             fin_ovf;

   assign stall    = valid_s[STAGES] && !out_ready;
   assign in_ready = !stall;

   assign valid_s[0] = in_valid;
   assign a_s[0]     = a;
   assign b_s[0]     = (sub == OP_SUB) ? ~b : b;
   assign sum_s[0]   = '0;
   assign carry_s[0] = (sub == OP_ADD) ? 1'b0 : 1'b1;
`ifdef PIPE_ADD_SUB_SAT_EN
   assign sat_s[0]   = sat;
`else
   assign sat_s[0]   = 1'b0;
`endif

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      add_sub_slice #(
         .WIDTH (WIDTH),
         .SW    (SW),
         .IDX   (k)
      ) u_slice (
         .clk       (clk),
         .reset     (reset),
         .stall     (stall),
         .in_valid  (valid_s[k]),
         .in_a      (a_s[k]),
         .in_b      (b_s[k]),
         .in_sum    (sum_s[k]),
         .in_carry  (carry_s[k]),
         .in_sat    (sat_s[k]),
         .out_valid (valid_s[k+1]),
         .out_a     (a_s[k+1]),
         .out_b     (b_s[k+1]),
         .out_sum   (sum_s[k+1]),
         .out_carry (carry_s[k+1]),
         .out_sat   (sat_s[k+1])
      );
   end

   // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
   assign fin_ovf = a_s[STAGES][WIDTH-1] ^ b_s[STAGES][WIDTH-1]
                  ^ sum_s[STAGES][WIDTH-1] ^ carry_s[STAGES];

   always_comb begin
      result = sum_s[STAGES];
`ifdef PIPE_ADD_SUB_SAT_EN
      if (sat_s[STAGES] && fin_ovf) begin
         result = sum_s[STAGES][WIDTH-1] ? SAT_POS : SAT_NEG;
      end
`endif
   end

   assign out_valid = valid_s[STAGES];
   assign carry_out = carry_s[STAGES];
   assign overflow  = fin_ovf;
   assign zero      = valid_s[STAGES] && (result == '0);

endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb/tb_pipelined_add_sub.sv - scoreboard bench for pipelined_add_sub (32x4 main, 8x1 registered-adder corner)
module tb_pipelined_add_sub;

`ifdef PIPE_ADD_SUB_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   typedef struct packed {
      logic [63:0] res;
      logic        c;
      logic        v;
      logic        z;
   } exp_t;

   typedef struct {
      exp_t e;
      int   issue;
      bit   lat;
   } sb_t;

   logic        clk;
   logic        reset;
   logic        in_valid, in_ready, sub, sat_v;
   logic [31:0] a, b, result;
   logic        out_valid, out_ready, carry_out, overflow, zero;

   logic        in_valid2, in_ready2, sub2, sat2;
   logic [7:0]  a2, b2, result2;
   logic        out_valid2, out_ready2, carry_out2, overflow2, zero2;

   int          n_checks;
   int          n_errors;
   int          cyc;
   logic        stall_prev;
   logic [31:0] res_prev;
   sb_t         sb_q [$];

   pipelined_add_sub #(.WIDTH(32), .STAGES(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
`ifdef PIPE_ADD_SUB_SAT_EN
      .sat       (sat_v),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry_out (carry_out),
      .overflow  (overflow),
      .zero      (zero)
   );

   pipelined_add_sub #(.WIDTH(8), .STAGES(1)) dut1 (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid2),
      .in_ready  (in_ready2),
      .a         (a2),
      .b         (b2),
      .sub       (sub2),
`ifdef PIPE_ADD_SUB_SAT_EN
      .sat       (sat2),
`endif
      .out_valid (out_valid2),
      .out_ready (out_ready2),
      .result    (result2),
      .carry_out (carry_out2),
      .overflow  (overflow2),
      .zero      (zero2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input int w, input logic [63:0] x, input logic [63:0] y,
                                  input logic s, input logic st);
      logic [63:0] mask, yb, r;
      logic [64:0] full;
      exp_t        e;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      x    = x & mask;
      yb   = (s ? ~y : y) & mask;
      full = {1'b0, x} + {1'b0, yb} + 65'(s);
      r    = full[63:0] & mask;
      e.c  = full[w];
      e.v  = (x[w-1] == yb[w-1]) && (r[w-1] != x[w-1]);
      if (SAT_EN && st && e.v) r = r[w-1] ? (mask >> 1) : (mask ^ (mask >> 1));
      e.res = r;
      e.z   = (r == 64'd0);
      return e;
   endfunction

   function automatic logic [31:0] rnd_op();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   // One cycle on the main DUT: drive at negedge, sample 1 ns later, then wait for next negedge.
   task automatic drive(input logic v, input logic [31:0] aa, input logic [31:0] bb, input logic s,
                        input logic st, input logic ordy, input bit lat);
      logic exp_rdy;
      sb_t  ent;
      in_valid  = v;
      a         = aa;
      b         = bb;
      sub       = s;
      sat_v     = st;
      out_ready = ordy;
      #1;
      exp_rdy = !(out_valid && !ordy);
      check_eq("in_ready", in_ready, exp_rdy);
      if (stall_prev) begin
         check_eq("hold_valid", out_valid, 1'b1);
         check_eq("hold_result", result, res_prev);
      end
      if (out_valid && ordy) begin
         if (sb_q.size() == 0) begin
            check_eq("spurious_out", out_valid, 1'b0);
         end else begin
            ent = sb_q.pop_front();
            check_eq("result", result, ent.e.res[31:0]);
            check_eq("carry_out", carry_out, ent.e.c);
            check_eq("overflow", overflow, ent.e.v);
            check_eq("zero", zero, ent.e.z);
            if (ent.lat) check_eq("latency", cyc - ent.issue, 4);
         end
      end
      if (v && exp_rdy) begin
         ent.e     = model(32, 64'(aa), 64'(bb), s, st);
         ent.issue = cyc;
         ent.lat   = lat;
         sb_q.push_back(ent);
      end
      stall_prev = out_valid && !ordy;
      res_prev   = result;
      cyc++;
      @(negedge clk);
   endtask

   task automatic bubbles(input int n, input bit lat);
      for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, lat);
   endtask

   task automatic drain();
      for (int i = 0; i < 64 && sb_q.size() != 0; i++) bubbles(1, 1'b0);
      check_eq("drain_empty", sb_q.size(), 0);
   endtask

   initial begin
      exp_t e1;
      logic p_v;
      exp_t p_e;

      n_checks   = 0;
      n_errors   = 0;
      cyc        = 0;
      stall_prev = 1'b0;
      res_prev   = '0;
      reset      = 1'b1;
      in_valid   = 1'b0;
      a          = '0;
      b          = '0;
      sub        = 1'b0;
      sat_v      = 1'b0;
      out_ready  = 1'b1;
      in_valid2  = 1'b0;
      a2         = '0;
      b2         = '0;
      sub2       = 1'b0;
      sat2       = 1'b0;
      out_ready2 = 1'b1;

      #2;
      check_eq("rst_out_valid", out_valid, 1'b0);
      check_eq("rst_result", result, 32'h0);
      check_eq("rst_carry", carry_out, 1'b0);
      check_eq("rst_overflow", overflow, 1'b0);
      check_eq("rst_zero", zero, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_eq("rst_in_ready", in_ready, 1'b1);
      @(negedge clk);

      // Directed operations, each checked for exact 4-cycle latency.
      drive(1'b1, 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 1'b1, 1'b1);
      bubbles(4, 1'b1);
      drive(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b1);
      drive(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 1'b1);
      drive(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b1, 1'b1);
      drive(1'b1, 32'h0000_0004, 32'h0000_0004, 1'b1, 1'b0, 1'b1, 1'b1);
      drive(1'b1, 32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 1'b1);
      drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b1);
      bubbles(5, 1'b1);
      drain();

      // Back-to-back stream of 10, then a stream with a 3-cycle backpressure window.
      for (int i = 0; i < 10; i++)
         drive(1'b1, 32'(i * 1000 + 7), 32'(i * 3), i[0], 1'b0, 1'b1, 1'b1);
      bubbles(4, 1'b1);
      drain();
      for (int i = 0; i < 12; i++)
         drive(1'b1, 32'(i + 100), 32'(i * 5), i[1], 1'b0, !(i >= 5 && i < 8), 1'b0);
      drain();

      // Reset with operations in flight.
      for (int i = 0; i < 4; i++)
         drive(1'b1, 32'(i + 1), 32'(i + 2), 1'b0, 1'b0, 1'b0, 1'b0);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      check_eq("pre_rst_valid", out_valid, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      check_eq("async_rst_valid", out_valid, 1'b0);
      check_eq("async_rst_result", result, 32'h0);
      check_eq("async_rst_in_ready", in_ready, 1'b1);
      sb_q.delete();
      stall_prev = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      bubbles(6, 1'b0);
      drive(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 1'b1, 1'b1);
      bubbles(5, 1'b1);
      drain();

      // Random regression with random in_valid / out_ready.
      for (int i = 0; i < 400; i++)
         drive($urandom_range(0, 3) != 0, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, 1'b0);
      drain();

      // STAGES=1: a registered adder with latency 1.
      p_v = 1'b0;
      p_e = '0;
      for (int i = 0; i < 40; i++) begin
         #1;
         check_eq("s1_valid", out_valid2, p_v);
         if (p_v) begin
            check_eq("s1_result", result2, p_e.res[7:0]);
            check_eq("s1_carry", carry_out2, p_e.c);
            check_eq("s1_overflow", overflow2, p_e.v);
            check_eq("s1_zero", zero2, p_e.z);
         end
         in_valid2 = (i % 7) != 3;
         if (i == 0) begin
            a2 = 8'hFF; b2 = 8'h01; sub2 = 1'b0;
         end else if (i == 1) begin
            a2 = 8'h7F; b2 = 8'h01; sub2 = 1'b0;
         end else begin
            a2 = 8'($urandom); b2 = 8'($urandom); sub2 = 1'($urandom_range(0, 1));
         end
         sat2 = 1'($urandom_range(0, 1));
         e1   = model(8, 64'(a2), 64'(b2), sub2, sat2);
         p_v  = in_valid2;
         p_e  = e1;
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
